// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and helpers for the memory slave and the miniTB master BFM.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'd0,
      HSIZE_HALF  = 3'd1,
      HSIZE_WORD  = 3'd2,
      HSIZE_DWORD = 3'd3
   } hsize_e;

   typedef enum logic [1:0] {
      ST_OKAY,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } slv_state_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Lanes covered by an access of 2**hsize bytes; low offset bits below the size alignment are dropped.
   function automatic logic [7:0] byte_mask(input logic [2:0] hsize, input logic [2:0] offset,
                                            input int nbytes);
      logic [7:0] mask;
      int         size_b;
      int         base;
      mask   = '0;
      size_b = 1 << hsize;
      base   = int'(offset) & ~(size_b - 1);
      for (int b = 0; b < 8; b++) begin
         mask[b] = (b < nbytes) && (b >= base) && (b < base + size_b);
      end
      return mask;
   endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-addressed memory split into one byte-wide array per lane: per-byte write, registered read, synchronous clear.
module ahb_mem_array #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 256,
   localparam int NB     = DATA_W / 8,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_clr,
   input  logic              i_we,
   input  logic [NB-1:0]     i_be,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         logic [7:0] r_lane [DEPTH];
         logic [7:0] r_rd;

         // Read returns the pre-write contents on a same-address collision.
         always_ff @(posedge i_clk) begin
            if (i_clr) begin
               for (int d = 0; d < DEPTH; d++) begin
                  r_lane[d] <= '0;
               end
               r_rd <= '0;
            end else begin
               if (i_we && i_be[gi]) begin
                  r_lane[i_waddr] <= i_wdata[8*gi +: 8];
               end
               r_rd <= r_lane[i_raddr];
            end
         end

         assign o_rdata[8*gi +: 8] = r_rd;
      end
   endgenerate

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: address decode, wait-state / two-cycle ERROR FSM and write-to-read forwarding.
module ahb_mem_slave
   import ahb_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 256,
   parameter int ADDR_W      = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              hsel,
   input  logic              hready,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [DATA_W-1:0] hwdata,
   output logic [DATA_W-1:0] hrdata,
   output logic              hreadyout,
   output logic              hresp
);

   localparam int NB     = DATA_W / 8;
   localparam int LANE_W = $clog2(NB);
   localparam int AW     = $clog2(DEPTH);
   localparam int IDX_W  = ADDR_W - LANE_W;

   htrans_e           w_trans;
   logic              w_accept;
   logic              w_oor;
   logic              w_wr_fire;
   logic              w_fwd_hit;
   logic [IDX_W-1:0]  w_idx_full;
   logic [LANE_W-1:0] w_offset;
   logic [AW-1:0]     w_raddr;
   logic [NB-1:0]     w_wr_be;
   logic [DATA_W-1:0] w_ram_rdata;
   logic [DATA_W-1:0] w_rd_merged;

   slv_state_e        r_state;
   logic              r_hreadyout;
   logic              r_hresp;
   logic [2:0]        r_wait_cnt;
   logic              r_dp_valid;
   logic              r_dp_write;
   logic [2:0]        r_dp_size;
   logic [LANE_W-1:0] r_dp_offset;
   logic [AW-1:0]     r_word_idx;
   logic              r_fwd_valid;
   logic [NB-1:0]     r_fwd_mask;
   logic [DATA_W-1:0] r_fwd_data;

   assign w_trans    = htrans_e'(htrans);
   assign w_offset   = haddr[LANE_W-1:0];
   assign w_idx_full = haddr[ADDR_W-1:LANE_W];
   // Accept is gated by our own ready so a stray hready during WAIT/ERR1 is ignored.
   assign w_accept   = hsel & hready & r_hreadyout &
                       ((w_trans == HTRANS_NONSEQ) || (w_trans == HTRANS_SEQ));
   assign w_oor      = (32'(w_idx_full) >= 32'(DEPTH)) || (32'(hsize) > 32'(LANE_W));
   assign w_wr_fire  = r_dp_valid & r_dp_write & r_hreadyout;
   assign w_wr_be    = NB'(byte_mask(r_dp_size, 3'(r_dp_offset), NB));
   assign w_raddr    = w_accept ? w_idx_full[AW-1:0] : r_word_idx;
   assign w_fwd_hit  = w_wr_fire & ~hwrite & (w_idx_full[AW-1:0] == r_word_idx);

   ahb_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .i_clk   (hclk),
      .i_clr   (hreset),
      .i_we    (w_wr_fire),
      .i_be    (w_wr_be),
      .i_waddr (r_word_idx),
      .i_wdata (hwdata),
      .i_raddr (w_raddr),
      .o_rdata (w_ram_rdata)
   );

   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_state     <= ST_OKAY;
         r_hreadyout <= 1'b1;
         r_hresp     <= HRESP_OKAY;
         r_wait_cnt  <= '0;
      end else begin
         case (r_state)
            ST_OKAY, ST_ERR2: begin
               if (w_accept && w_oor) begin
                  r_state     <= ST_ERR1;
                  r_hreadyout <= 1'b0;
                  r_hresp     <= HRESP_ERROR;
               end else if (w_accept && (WAIT_STATES > 0)) begin
                  r_state     <= ST_WAIT;
                  r_hreadyout <= 1'b0;
                  r_hresp     <= HRESP_OKAY;
                  r_wait_cnt  <= 3'(WAIT_STATES);
               end else begin
                  r_state     <= ST_OKAY;
                  r_hreadyout <= 1'b1;
                  r_hresp     <= HRESP_OKAY;
               end
            end
            ST_WAIT: begin
               if (r_wait_cnt == 3'd1) begin
                  r_state     <= ST_OKAY;
                  r_hreadyout <= 1'b1;
               end
               r_wait_cnt <= r_wait_cnt - 3'd1;
            end
            ST_ERR1: begin
               r_state     <= ST_ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= HRESP_ERROR;
            end
            default: begin
               r_state     <= ST_OKAY;
               r_hreadyout <= 1'b1;
               r_hresp     <= HRESP_OKAY;
            end
         endcase
      end
   end

   // Data-phase context; r_dp_valid is held through WAIT and cleared for errored transfers.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_dp_valid  <= 1'b0;
         r_dp_write  <= 1'b0;
         r_dp_size   <= '0;
         r_dp_offset <= '0;
         r_word_idx  <= '0;
         r_fwd_valid <= 1'b0;
         r_fwd_mask  <= '0;
         r_fwd_data  <= '0;
      end else if (w_accept) begin
         r_dp_valid  <= ~w_oor;
         r_dp_write  <= hwrite;
         r_dp_size   <= hsize;
         r_dp_offset <= w_offset;
         r_word_idx  <= w_idx_full[AW-1:0];
         r_fwd_valid <= w_fwd_hit & ~w_oor;
         r_fwd_mask  <= w_wr_be;
         r_fwd_data  <= hwdata;
      end else if (r_hreadyout) begin
         r_dp_valid  <= 1'b0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_fwd
         assign w_rd_merged[8*gi +: 8] = (r_fwd_valid && r_fwd_mask[gi]) ?
                                         r_fwd_data[8*gi +: 8] : w_ram_rdata[8*gi +: 8];
      end
   endgenerate

   assign hrdata    = (r_dp_valid && !r_dp_write && r_hreadyout) ? w_rd_merged : '0;
   assign hreadyout = r_hreadyout;
   assign hresp     = r_hresp;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: one zero-wait instance and one three-wait instance on a shared bus.
module tb_ahb_mem_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel;
   logic        sel3;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [11:0] haddr;
   logic [31:0] hwdata;

   logic [31:0] rd0, rd3, cur_rd;
   logic        rdy0, rdy3, resp0, resp3, cur_rdy, cur_resp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ahb_mem_slave #(.DATA_W(32), .DEPTH(256), .ADDR_W(12), .WAIT_STATES(0)) dut0 (
      .hclk      (clk),
      .hreset    (rst),
      .hsel      (hsel & ~sel3),
      .hready    (rdy0),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .haddr     (haddr),
      .hwdata    (hwdata),
      .hrdata    (rd0),
      .hreadyout (rdy0),
      .hresp     (resp0)
   );

   ahb_mem_slave #(.DATA_W(32), .DEPTH(256), .ADDR_W(12), .WAIT_STATES(3)) dut3 (
      .hclk      (clk),
      .hreset    (rst),
      .hsel      (hsel & sel3),
      .hready    (rdy3),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .haddr     (haddr),
      .hwdata    (hwdata),
      .hrdata    (rd3),
      .hreadyout (rdy3),
      .hresp     (resp3)
   );

   assign cur_rd   = sel3 ? rd3 : rd0;
   assign cur_rdy  = sel3 ? rdy3 : rdy0;
   assign cur_resp = sel3 ? resp3 : resp0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      hsel   = 1'b0;
      htrans = 2'd0;
   endtask

   task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [11:0] addr);
      hsel   = 1'b1;
      htrans = 2'd2;
      hwrite = wr;
      hsize  = sz;
      haddr  = addr;
   endtask

   // Single transfer: address phase, then data phase until hreadyout (bounded).
   task automatic xfer(input logic wr, input logic [2:0] sz, input logic [11:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output int waits,
                       output logic err, output logic early_nz);
      addr_phase(wr, sz, addr);
      tick();
      go_idle();
      hwdata   = wd;
      waits    = 0;
      early_nz = 1'b0;
      @(negedge clk);
      while (!cur_rdy && waits < 16) begin
         waits++;
         if (cur_rd != 32'h0) early_nz = 1'b1;
         tick();
         @(negedge clk);
      end
      rd  = cur_rd;
      err = cur_resp;
      tick();
      $display("xfer dut%0d %s size=%0d addr=0x%03h wdata=0x%08h rdata=0x%08h waits=%0d resp=%0d",
               sel3 ? 3 : 0, wr ? "WR" : "RD", sz, addr, wd, rd, waits, err);
   endtask

   logic [31:0] rd;
   int          waits;
   logic        err, early_nz;

   initial begin
      rst = 1'b1; sel3 = 1'b0; hwrite = 1'b0; hsize = 3'd2; haddr = '0; hwdata = '0;
      go_idle();
      repeat (2) tick();
      @(negedge clk);
      check_val("rst_ready0", 32'(rdy0), 32'd1);
      check_val("rst_resp0",  32'(resp0), 32'd0);
      check_val("rst_rdata0", rd0, 32'h0);
      check_val("rst_ready3", 32'(rdy3), 32'd1);
      tick();
      rst = 1'b0;

      // 0-wait read of word 0, checked every cycle
      addr_phase(1'b0, 3'd2, 12'h000);
      @(negedge clk);
      check_val("rd0_ap_ready", 32'(cur_rdy), 32'd1);
      check_val("rd0_ap_resp", 32'(cur_resp), 32'd0);
      tick();
      go_idle();
      @(negedge clk);
      check_val("rd0_dp_rdata", cur_rd, 32'h0);
      check_val("rd0_dp_ready", 32'(cur_rdy), 32'd1);
      check_val("rd0_dp_resp", 32'(cur_resp), 32'd0);
      tick();

      xfer(1'b1, 3'd2, 12'h034, 32'h5A5A5A5A, rd, waits, err, early_nz);
      check_val("wr34_waits", 32'(waits), 32'd0);
      check_val("wr34_resp", 32'(err), 32'd0);
      xfer(1'b0, 3'd2, 12'h034, 32'h0, rd, waits, err, early_nz);
      check_val("rd34", rd, 32'h5A5A5A5A);

      xfer(1'b1, 3'd2, 12'h034, 32'h11223344, rd, waits, err, early_nz);
      xfer(1'b1, 3'd0, 12'h035, 32'h99AAEEBB, rd, waits, err, early_nz);
      xfer(1'b0, 3'd2, 12'h034, 32'h0, rd, waits, err, early_nz);
      check_val("byte_wr35", rd, 32'h1122EE44);
      xfer(1'b1, 3'd1, 12'h037, 32'hCAFE7788, rd, waits, err, early_nz);
      xfer(1'b0, 3'd2, 12'h034, 32'h0, rd, waits, err, early_nz);
      check_val("half_wr37_unaligned", rd, 32'hCAFEEE44);

      // Read accepted in the write's data phase must see the new data
      addr_phase(1'b1, 3'd2, 12'h010);
      tick();
      hwdata = 32'h0000000A;
      addr_phase(1'b0, 3'd2, 12'h010);
      tick();
      go_idle();
      @(negedge clk);
      check_val("fwd_rd10", cur_rd, 32'h0000000A);
      tick();
      $display("xfer dut0 WR+RD back-to-back addr=0x010 forwarded");
      xfer(1'b0, 3'd2, 12'h010, 32'h0, rd, waits, err, early_nz);
      check_val("rd10_after", rd, 32'h0000000A);

      // Out-of-range word index DEPTH; word 0 must stay intact
      xfer(1'b1, 3'd2, 12'h000, 32'h12345678, rd, waits, err, early_nz);
      addr_phase(1'b1, 3'd2, 12'h400);
      tick();
      hwdata = 32'hDEADBEEF;
      go_idle();
      @(negedge clk);
      check_val("err1_ready", 32'(cur_rdy), 32'd0);
      check_val("err1_resp", 32'(cur_resp), 32'd1);
      tick();
      @(negedge clk);
      check_val("err2_ready", 32'(cur_rdy), 32'd1);
      check_val("err2_resp", 32'(cur_resp), 32'd1);
      tick();
      @(negedge clk);
      check_val("err_done_ready", 32'(cur_rdy), 32'd1);
      check_val("err_done_resp", 32'(cur_resp), 32'd0);
      tick();
      $display("xfer dut0 WR size=2 addr=0x400 -> ERROR");
      xfer(1'b0, 3'd2, 12'h000, 32'h0, rd, waits, err, early_nz);
      check_val("rd0_after_err", rd, 32'h12345678);

      // Oversized hsize errors; a read held through ERR1 is taken in ERR2
      addr_phase(1'b0, 3'd3, 12'h020);
      tick();
      addr_phase(1'b0, 3'd2, 12'h034);
      @(negedge clk);
      check_val("sz_err1_ready", 32'(cur_rdy), 32'd0);
      check_val("sz_err1_rdata", cur_rd, 32'h0);
      tick();
      @(negedge clk);
      check_val("sz_err2_resp", 32'(cur_resp), 32'd1);
      tick();
      go_idle();
      @(negedge clk);
      check_val("err2_accept_rd34", cur_rd, 32'hCAFEEE44);
      check_val("err2_accept_resp", 32'(cur_resp), 32'd0);
      tick();
      $display("xfer dut0 RD size=3 -> ERROR, then RD addr=0x034 in ERR2");

      // W=3: 10-beat SEQ write burst
      sel3 = 1'b1;
      begin
         int   ap, dp, cyc;
         logic rdy, done;
         ap = 0; dp = -1; cyc = 0; done = 1'b0;
         addr_phase(1'b1, 3'd2, 12'h080);
         for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            rdy = cur_rdy;
            if (dp >= 0) cyc++;
            if (rdy && dp == 9) done = 1'b1;
            tick();
            if (rdy) begin
               dp = (ap < 10) ? ap : -1;
               ap++;
               if (ap < 10) begin
                  addr_phase(1'b1, 3'd2, 12'h080 + 12'(4 * ap));
                  htrans = 2'd3;
               end else begin
                  go_idle();
               end
               if (dp >= 0) hwdata = 32'h100 + 32'(dp);
            end
         end
         $display("xfer dut3 WR burst 10 beats addr=0x080 cycles=%0d", cyc);
         check_val("burst_done", 32'(done), 32'd1);
         check_val("burst_cycles", 32'(cyc), 32'd40);
      end
      xfer(1'b0, 3'd2, 12'h080, 32'h0, rd, waits, err, early_nz);
      check_val("w3_rd_waits", 32'(waits), 32'd3);
      check_val("w3_rd_data", rd, 32'h00000100);
      check_val("w3_rd_zero_early", 32'(early_nz), 32'd0);
      xfer(1'b0, 3'd2, 12'h0A4, 32'h0, rd, waits, err, early_nz);
      check_val("w3_rd_beat9", rd, 32'h00000109);
      sel3 = 1'b0;

      // Reset asserted during ERR1
      addr_phase(1'b1, 3'd2, 12'h400);
      tick();
      go_idle();
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_err1_ready", 32'(cur_rdy), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_err1_after_ready", 32'(cur_rdy), 32'd1);
      check_val("rst_err1_after_resp", 32'(cur_resp), 32'd0);
      tick();
      $display("xfer dut0 WR addr=0x400 -> reset in ERR1");
      xfer(1'b0, 3'd2, 12'h034, 32'h0, rd, waits, err, early_nz);
      check_val("mem_cleared", rd, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/ahb_mem_slave.md
# ahb_mem_slave

Parametrised AHB-Lite memory slave: the next generation of the team's fixed 8-bit-address/32-bit-word slave. Adds configurable data width and depth, byte/halfword/word writes via `hsize`, programmable wait states, `hsel` decode and a two-cycle ERROR response for out-of-range addresses. It sits behind the AHB master/interconnect and is exercised by the miniTB AHB master BFM.

## Interface
- `DATA_W`, 32: data bus width; one of 32 or 64.
- `DEPTH`, 256: memory depth in words; must be a power of 2.
- `ADDR_W`, 12: `haddr` width in bits; byte address.
- `WAIT_STATES`, 0: cycles `hreadyout` is held low per NONSEQ/SEQ transfer; range 0..7.
- `hclk`  in  1  clock; all logic is on the rising edge.
- `hreset`  in  1  synchronous reset, active-high.
- `hsel`  in  1  slave select.
- `hready`  in  1  bus ready; a new address phase is accepted only when this is high.
- `htrans`  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite`  in  1  1 = write.
- `hsize`  in  3  0 = byte, 1 = half, 2 = word, 3 = dword (dword only when `DATA_W`=64).
- `haddr`  in  `ADDR_W`  byte address.
- `hwdata`  in  `DATA_W`  write data; sampled in the data phase.
- `hrdata`  out  `DATA_W`  read data.
- `hreadyout`  out  1  slave ready.
- `hresp`  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Address-phase accept condition: `hsel & hready & htrans[1]`.
- On accept, register `hwrite`, `hsize`, the byte lane offset and word index `haddr[ADDR_W-1:log2(DATA_W/8)]`.
- IDLE/BUSY transfers, and cycles with `hsel`=0, get a zero-wait OKAY.
- Out-of-range: a word index ≥ `DEPTH`, or `hsize` larger than the bus. Either gives an ERROR response; memory is not modified and `hrdata` is 0.
- Writes:
  - Byte-enable mask is decoded from the registered `hsize` and lane offset. An unaligned address ignores the low bits below the size alignment.
  - Masked lanes of `hwdata` are written on the final data-phase cycle (`hreadyout`=1).
- Reads: `hrdata` carries the full word; lanes outside the mask return the stored value.
- Write-to-read forwarding: a read to the same word that is accepted in the same cycle as the write completes must return the merged new data.
- FSM states:
  - OKAY: `hreadyout`=1, `hresp`=0.
  - WAIT: counter runs `WAIT_STATES`→1, `hreadyout`=0.
  - ERR1: `hreadyout`=0, `hresp`=1.
  - ERR2: `hreadyout`=1, `hresp`=1.
- FSM transitions:
  - Valid accept: → WAIT if `WAIT_STATES`>0, else stay in OKAY.
  - Out-of-range accept: → ERR1 → ERR2 → OKAY.
  - ERR2 with a new accept in the same cycle: processed normally.
- A master dropping `htrans` to IDLE during ERR1 is legal; the slave still completes ERR2.
- Reset:
  - Memory cleared to 0, FSM → OKAY.
  - `hreadyout`=1, `hresp`=0, `hrdata`=0.
  - Reset asserted mid-transfer discards the pending write and any wait count.

## Timing
- Zero wait states:
  - Address phase in cycle N.
  - Write data sampled at the end of cycle N+1; memory is visible from N+2.
  - Read `hrdata` valid in N+1.
- With `WAIT_STATES`=W: data phase spans W+1 cycles, and `hreadyout` is low for the first W.
  - `hwdata` must be stable throughout; it is sampled on the last cycle only.
  - `hrdata` is valid only on the last cycle and is 0 before it.
- Back-to-back: sustained 1 transfer/cycle at W=0, 1 per W+1 cycles otherwise.
- ERROR: always exactly 2 data-phase cycles, independent of W.
- No combinational path from `hwdata` to `hrdata`, except the forwarding mux, which uses registered data.

## Structure
- Package `ahb_pkg`: `htrans_e`, `hsize_e`, the `HRESP_OKAY`/`HRESP_ERROR` constants and the function `byte_mask(hsize, offset, DATA_W/8)`. It is shared with the miniTB AHB master.
- One sub-module, `ahb_mem_array`:
  - `DEPTH`×`DATA_W` register array.
  - Per-byte write enable.
  - Synchronous read, synchronous clear.
- The FSM, decode and forwarding live in the top level.

## Test plan
- Reset, then a 0-wait read of word 0 → `hrdata`=0, `hreadyout`=1, `hresp`=0 on every cycle.
- NONSEQ word write 0x5A5A5A5A to 0x34 (W=0), then read 0x34 → `mem[0x0D]`=0x5A5A5A5A two cycles after the address phase; read returns 0x5A5A5A5A.
- Byte write 0xEE to 0x35 over a word holding 0x11223344 → word becomes 0x1122EE44.
- Back-to-back write 0xA to 0x10, read 0x10 accepted in the write's data phase → read returns 0xA (forwarding).
- W=3: a NONSEQ read shows `hreadyout` low for exactly 3 cycles, with data valid on the 4th; a 10-beat SEQ write burst takes 40 cycles.
- Write to word index `DEPTH`:
  - → ERR1 (`hreadyout`=0, `hresp`=1), then ERR2 (`hreadyout`=1, `hresp`=1), then OKAY.
  - Memory is unchanged.
  - Reset asserted during ERR1 → next cycle `hreadyout`=1, `hresp`=0.
